fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have one clock, clk_i, and one reset, rsn_i; reset is asynchronous and active-low.
REQ-002 SHALL have parameters: BOOT_PC, 32'h0000_1000, reset PC; BTB_ENTRIES, 8, BTB depth (power of 2).
REQ-003 Ports, name / direction / width / meaning:
- clk_i  in  1  clock
- rsn_i  in  1  async active-low reset
- stall_core_i  in  1  downstream latch holding; buffered instruction not consumed
- redirect_i  in  1  resolved mispredict/jump/trap from later stage
- redirect_pc_i  in  32  new fetch PC on redirect
- bp_update_i  in  1  branch resolved, update BTB
- bp_update_pc_i  in  32  PC of resolved branch
- bp_update_target_i  in  32  resolved target
- bp_update_taken_i  in  1  resolved direction
- imem_req_o  out  1  instruction memory request
- imem_addr_o  out  32  request address
- imem_ack_i  in  1  memory response valid
- imem_data_i  in  32  instruction word
- imem_err_i  in  1  access fault, qualified by imem_ack_i
- fetch_instr_o, fetch_pc_o, fetch_pred_pc_o  out  32 each  buffered instruction, its PC, predicted next PC
- fetch_prediction_o  out  1  BTB hit
- fetch_taken_o  out  1  predicted taken
- fetch_misaligned_instr_exc_o, fetch_instr_fault_exc_o  out  1 each  exception flags
- stall_fetch_o  out  1  no valid instruction this cycle (bubble)

Function
REQ-004 SHALL implement FSM states FETCH, VALID, FLUSH.
REQ-005 In FETCH: if pc[1:0]!=0, imem_req_o=0; next edge loads buffer with instr=0, misaligned=1, other flags 0, and goes to VALID.
REQ-006 In FETCH (aligned): imem_req_o=1, imem_addr_o=pc; address SHALL stay stable until imem_ack_i.
REQ-007 On ack in FETCH: buffer captures instr=imem_data_i (0 if imem_err_i), fault=imem_err_i, pc, BTB lookup result; goes to VALID next edge.
REQ-008 Zero-wait memory (ack in the request cycle) SHALL give buffer valid the following cycle; peak throughput is one instruction per 2 cycles.
REQ-009 In VALID: imem_req_o=0, stall_fetch_o=0, outputs show the buffer; at an edge with stall_core_i=0, pc<=fetch_pred_pc_o and go to FETCH; with stall_core_i=1, hold all state.
REQ-010 stall_fetch_o SHALL be 1 in FETCH and FLUSH.
REQ-011 BTB: direct-mapped, index pc[4:2] (log2 BTB_ENTRIES bits above bit 1), entry = valid, tag pc[31:5], target, 2-bit counter.
REQ-012 Lookup hit (valid and tag match): prediction=1, taken=ctr[1], pred_pc = taken ? target : pc+4; miss: prediction=0, taken=0, pred_pc=pc+4; pc+4 wraps modulo 2^32.
REQ-013 Update on bp_update_i: on tag miss or invalid entry, write valid=1, tag, target, ctr=taken?2'b10:2'b01; on hit, write target and saturate ctr up (taken) or down (not taken), bounded 00..11.
REQ-014 Lookup and update to the same index in the same cycle: lookup SHALL see pre-update contents.
REQ-015 redirect_i SHALL override stall_core_i and every FSM transition: pc<=redirect_pc_i, buffer and all exception flags cleared.
REQ-016 Redirect in VALID, or in FETCH with no outstanding request or with ack the same cycle: next state FETCH, any acked data discarded.
REQ-017 Redirect in FETCH with request outstanding and no ack: go to FLUSH, keeping imem_req_o=1 and the old address until ack; on ack discard data and go to FETCH with the redirected PC.
REQ-018 Redirect while in FLUSH: update the pending PC only and stay in FLUSH.
REQ-019 redirect_i and bp_update_i in the same cycle SHALL both take effect.

Reset
REQ-020 On rsn_i=0, asynchronously: state FETCH, pc=BOOT_PC, all buffer/output registers 0, stall_fetch_o=1, all BTB valid=0 and ctr=2'b01; imem_req_o=1 to BOOT_PC on the first cycle after release.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction; memory is reset by the same rsn_i.

Verification
REQ-022 Reset release, ack data 32'h00000013 one cycle later -> imem_addr_o=32'h1000, then fetch_pc_o=32'h1000, pred_pc=32'h1004, prediction=0, stall_fetch_o=0.
REQ-023 bp_update pc=32'h1008, target=32'h2000, taken=1, then fetch 32'h1008 -> prediction=1, taken=1, pred_pc=32'h2000; next request address 32'h2000.
REQ-024 Three not-taken updates on that entry -> ctr 10->01->00->00 (saturates); fetch gives taken=0, pred_pc=32'h100C.
REQ-025 Redirect to 32'h3000 while request to 32'h1004 outstanding, ack 3 cycles later -> req held at 32'h1004 until ack, data dropped, next request 32'h3000, no valid output in between.
REQ-026 redirect_pc_i=32'h3002 -> imem_req_o stays 0, misaligned=1, instr=0; imem_ack_i with imem_err_i=1 -> fault=1, instr=0.
REQ-027 stall_core_i=1 for 4 cycles in VALID -> outputs constant, no new request; pc=32'hFFFF_FFFC with BTB miss -> pred_pc=32'h0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-entry fetch buffer, direct-mapped BTB with 2-bit
// counters, and redirect handling that drains an in-flight memory request.
module fetch_unit #(
    parameter logic [31:0] BOOT_PC     = 32'h0000_1000,
    parameter int unsigned BTB_ENTRIES = 8
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        stall_core_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        bp_update_i,
    input  logic [31:0] bp_update_pc_i,
    input  logic [31:0] bp_update_target_i,
    input  logic        bp_update_taken_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        imem_err_i,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic [31:0] fetch_pred_pc_o,
    output logic        fetch_prediction_o,
    output logic        fetch_taken_o,
    output logic        fetch_misaligned_instr_exc_o,
    output logic        fetch_instr_fault_exc_o,
    output logic        stall_fetch_o
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {FETCH, VALID, FLUSH} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] flush_addr_q, flush_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] bpc_q, bpc_d;
    logic [31:0] pred_pc_q, pred_pc_d;
    logic        prediction_q, prediction_d;
    logic        taken_q, taken_d;
    logic        mis_q, mis_d;
    logic        fault_q, fault_d;

    logic             btb_valid_q  [BTB_ENTRIES];
    logic             btb_valid_d  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag_q    [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag_d    [BTB_ENTRIES];
    logic [31:0]      btb_target_q [BTB_ENTRIES];
    logic [31:0]      btb_target_d [BTB_ENTRIES];
    logic [1:0]       btb_ctr_q    [BTB_ENTRIES];
    logic [1:0]       btb_ctr_d    [BTB_ENTRIES];

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    logic [IDX_W-1:0] lk_idx;
    logic             lk_hit, lk_taken;
    logic [31:0]      pc_plus4, lk_pred;
    logic             misaligned;

    assign lk_idx     = pc_q[IDX_W+1:2];
    assign lk_hit     = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == pc_q[31:IDX_W+2]);
    assign lk_taken   = lk_hit && btb_ctr_q[lk_idx][1];
    assign pc_plus4   = pc_q + 32'd4;
    assign lk_pred    = lk_taken ? btb_target_q[lk_idx] : pc_plus4;
    assign misaligned = (pc_q[1:0] != 2'b00);

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       upd_cur, upd_ctr;
    logic             unused_bits;

    assign upd_idx     = bp_update_pc_i[IDX_W+1:2];
    assign upd_tag     = bp_update_pc_i[31:IDX_W+2];
    assign upd_hit     = btb_valid_q[upd_idx] && (btb_tag_q[upd_idx] == upd_tag);
    assign upd_cur     = btb_ctr_q[upd_idx];
    assign unused_bits = ^bp_update_pc_i[1:0];

    always_comb begin
        upd_ctr = bp_update_taken_i ? 2'b10 : 2'b01;
        if (upd_hit) begin
            if (bp_update_taken_i) upd_ctr = (upd_cur == 2'b11) ? 2'b11 : upd_cur + 2'd1;
            else                   upd_ctr = (upd_cur == 2'b00) ? 2'b00 : upd_cur - 2'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid_d[i]  = btb_valid_q[i];
            btb_tag_d[i]    = btb_tag_q[i];
            btb_target_d[i] = btb_target_q[i];
            btb_ctr_d[i]    = btb_ctr_q[i];
        end
        if (bp_update_i) begin
            btb_valid_d[upd_idx]  = 1'b1;
            btb_tag_d[upd_idx]    = upd_tag;
            btb_target_d[upd_idx] = bp_update_target_i;
            btb_ctr_d[upd_idx]    = upd_ctr;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
                btb_ctr_q[i]    <= 2'b01;
            end
        end else begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i]  <= btb_valid_d[i];
                btb_tag_q[i]    <= btb_tag_d[i];
                btb_target_q[i] <= btb_target_d[i];
                btb_ctr_q[i]    <= btb_ctr_d[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        flush_addr_d  = flush_addr_q;
        instr_d       = instr_q;
        bpc_d         = bpc_q;
        pred_pc_d     = pred_pc_q;
        prediction_d  = prediction_q;
        taken_d       = taken_q;
        mis_d         = mis_q;
        fault_d       = fault_q;
        imem_req_o    = 1'b0;
        imem_addr_o   = pc_q;
        stall_fetch_o = 1'b1;

        case (state_q)
            FETCH: begin
                imem_req_o = !misaligned;
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                    // An unanswered request must be drained before the new PC goes out.
                    if (!misaligned && !imem_ack_i) begin
                        state_d      = FLUSH;
                        flush_addr_d = pc_q;
                    end
                end else if (misaligned) begin
                    instr_d      = '0;
                    bpc_d        = pc_q;
                    pred_pc_d    = pc_plus4;
                    prediction_d = 1'b0;
                    taken_d      = 1'b0;
                    mis_d        = 1'b1;
                    fault_d      = 1'b0;
                    state_d      = VALID;
                end else if (imem_ack_i) begin
                    instr_d      = imem_err_i ? 32'd0 : imem_data_i;
                    bpc_d        = pc_q;
                    pred_pc_d    = lk_pred;
                    prediction_d = lk_hit;
                    taken_d      = lk_taken;
                    mis_d        = 1'b0;
                    fault_d      = imem_err_i;
                    state_d      = VALID;
                end
            end
            VALID: begin
                stall_fetch_o = 1'b0;
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = FETCH;
                end else if (!stall_core_i) begin
                    pc_d    = pred_pc_q;
                    state_d = FETCH;
                end
            end
            FLUSH: begin
                imem_req_o  = 1'b1;
                imem_addr_o = flush_addr_q;
                if (redirect_i) pc_d = redirect_pc_i;
                if (imem_ack_i) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        if (redirect_i) begin
            instr_d      = '0;
            bpc_d        = '0;
            pred_pc_d    = '0;
            prediction_d = 1'b0;
            taken_d      = 1'b0;
            mis_d        = 1'b0;
            fault_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q      <= FETCH;
            pc_q         <= BOOT_PC;
            flush_addr_q <= '0;
            instr_q      <= '0;
            bpc_q        <= '0;
            pred_pc_q    <= '0;
            prediction_q <= 1'b0;
            taken_q      <= 1'b0;
            mis_q        <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            flush_addr_q <= flush_addr_d;
            instr_q      <= instr_d;
            bpc_q        <= bpc_d;
            pred_pc_q    <= pred_pc_d;
            prediction_q <= prediction_d;
            taken_q      <= taken_d;
            mis_q        <= mis_d;
            fault_q      <= fault_d;
        end
    end

    assign fetch_instr_o                = instr_q;
    assign fetch_pc_o                   = bpc_q;
    assign fetch_pred_pc_o              = pred_pc_q;
    assign fetch_prediction_o           = prediction_q;
    assign fetch_taken_o                = taken_q;
    assign fetch_misaligned_instr_exc_o = mis_q;
    assign fetch_instr_fault_exc_o      = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetch traffic
// checked against a table-level BTB model.
module tb_fetch_unit;
    logic        clk_i = 1'b0;
    logic        rsn_i;
    logic        stall_core_i, redirect_i, bp_update_i, bp_update_taken_i;
    logic [31:0] redirect_pc_i, bp_update_pc_i, bp_update_target_i;
    logic        imem_req_o, imem_ack_i, imem_err_i;
    logic [31:0] imem_addr_o, imem_data_i;
    logic [31:0] fetch_instr_o, fetch_pc_o, fetch_pred_pc_o;
    logic        fetch_prediction_o, fetch_taken_o;
    logic        fetch_misaligned_instr_exc_o, fetch_instr_fault_exc_o, stall_fetch_o;

    fetch_unit #(.BOOT_PC(32'h0000_1000), .BTB_ENTRIES(8)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .stall_core_i(stall_core_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .bp_update_i(bp_update_i), .bp_update_pc_i(bp_update_pc_i),
        .bp_update_target_i(bp_update_target_i), .bp_update_taken_i(bp_update_taken_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
        .imem_data_i(imem_data_i), .imem_err_i(imem_err_i),
        .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o),
        .fetch_pred_pc_o(fetch_pred_pc_o), .fetch_prediction_o(fetch_prediction_o),
        .fetch_taken_o(fetch_taken_o),
        .fetch_misaligned_instr_exc_o(fetch_misaligned_instr_exc_o),
        .fetch_instr_fault_exc_o(fetch_instr_fault_exc_o), .stall_fetch_o(stall_fetch_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] model_pc;

    // Reference BTB: one slot per word-index modulo 8, tag is the whole upper PC.
    bit          m_valid [8];
    logic [31:0] m_tag   [8];
    logic [31:0] m_tgt   [8];
    int          m_ctr   [8];

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output bit hit,
                                         output bit tk, output logic [31:0] ppc);
        int idx = int'((pc >> 2) % 8);
        hit = m_valid[idx] && (m_tag[idx] == (pc >> 5));
        tk  = hit && (m_ctr[idx] >= 2);
        ppc = tk ? m_tgt[idx] : pc + 32'd4;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
        int idx = int'((pc >> 2) % 8);
        if (!(m_valid[idx] && m_tag[idx] == (pc >> 5))) begin
            m_valid[idx] = 1; m_tag[idx] = pc >> 5; m_tgt[idx] = tgt; m_ctr[idx] = tk ? 2 : 1;
        end else begin
            m_tgt[idx] = tgt;
            if (tk) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
            else    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        end
    endfunction

    function automatic logic [31:0] rand_pc();
        return 32'h1000 + ($urandom_range(0, 15) << 2);
    endfunction

    function automatic logic [101:0] obs_now();
        return {fetch_instr_o, fetch_pc_o, fetch_pred_pc_o, fetch_prediction_o, fetch_taken_o,
                fetch_misaligned_instr_exc_o, fetch_instr_fault_exc_o, stall_fetch_o, imem_req_o};
    endfunction

    task automatic quiet();
        stall_core_i = 0; redirect_i = 0; redirect_pc_i = 0;
        bp_update_i = 0; bp_update_pc_i = 0; bp_update_target_i = 0; bp_update_taken_i = 0;
        imem_ack_i = 0; imem_data_i = 0; imem_err_i = 0;
    endtask

    // One full transaction from a FETCH cycle with model_pc outstanding; ends at the next FETCH.
    task automatic do_fetch(input int lat, input logic [31:0] data, input bit err,
                            input bit upd, input int hold);
        bit hit, tk, u_tk;
        logic [31:0] ppc, u_pc, u_tgt;
        logic [101:0] exp_o, obs;
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== model_pc) begin
            n_err++;
            $display("FAIL req_start: req=%b addr=%h, expected req=1 addr=%h", imem_req_o, imem_addr_o, model_pc);
        end
        for (int i = 0; i < lat; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== model_pc || stall_fetch_o !== 1'b1) begin
                n_err++;
                $display("FAIL req_hold: req=%b addr=%h stall=%b, expected 1 %h 1", imem_req_o, imem_addr_o, stall_fetch_o, model_pc);
            end
        end
        model_lookup(model_pc, hit, tk, ppc);
        exp_o = {(err ? 32'd0 : data), model_pc, ppc, hit, tk, 1'b0, err, 1'b0, 1'b0};
        imem_ack_i = 1; imem_data_i = data; imem_err_i = err;
        if (upd) begin
            u_pc = rand_pc(); u_tgt = rand_pc(); u_tk = 1'($urandom_range(0, 1));
            bp_update_i = 1; bp_update_pc_i = u_pc; bp_update_target_i = u_tgt; bp_update_taken_i = u_tk;
            model_update(u_pc, u_tgt, u_tk);
        end
        stall_core_i = (hold > 0);
        @(negedge clk_i);
        imem_ack_i = 0; imem_err_i = 0; bp_update_i = 0;
        obs = obs_now();
        n_cmp++;
        if (obs !== exp_o) begin
            n_err++;
            $display("FAIL fetch_out pc=%h: got %h, expected %h", model_pc, obs, exp_o);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            obs = obs_now();
            n_cmp++;
            if (obs !== exp_o) begin
                n_err++;
                $display("FAIL stall_hold cycle %0d: got %h, expected %h", h, obs, exp_o);
            end
            if (h == hold - 1) stall_core_i = 0;
        end
        $display("fetch pc=%h lat=%0d err=%0d hit=%0d taken=%0d pred=%h hold=%0d", model_pc, lat, err, hit, tk, ppc, hold);
        @(negedge clk_i);
        model_pc = ppc;
    endtask

    task automatic redirect_to(input logic [31:0] pc, input bit upd);
        logic [31:0] u_pc, u_tgt;
        bit u_tk;
        redirect_i = 1; redirect_pc_i = pc;
        if (imem_req_o) begin imem_ack_i = 1; imem_data_i = $urandom; end
        if (upd) begin
            u_pc = rand_pc(); u_tgt = rand_pc(); u_tk = 1'($urandom_range(0, 1));
            bp_update_i = 1; bp_update_pc_i = u_pc; bp_update_target_i = u_tgt; bp_update_taken_i = u_tk;
            model_update(u_pc, u_tgt, u_tk);
        end
        @(negedge clk_i);
        redirect_i = 0; imem_ack_i = 0; bp_update_i = 0;
        model_pc = pc;
        n_cmp++;
        if (stall_fetch_o !== 1'b1 || fetch_instr_o !== 32'd0 || fetch_pc_o !== 32'd0 ||
            fetch_misaligned_instr_exc_o !== 1'b0 || fetch_instr_fault_exc_o !== 1'b0 ||
            imem_req_o !== (pc[1:0] == 2'b00) || (pc[1:0] == 2'b00 && imem_addr_o !== pc)) begin
            n_err++;
            $display("FAIL redirect %h: stall=%b instr=%h pc=%h mis=%b flt=%b req=%b addr=%h", pc,
                     stall_fetch_o, fetch_instr_o, fetch_pc_o, fetch_misaligned_instr_exc_o,
                     fetch_instr_fault_exc_o, imem_req_o, imem_addr_o);
        end
        $display("redirect to %h upd=%0d", pc, upd);
    endtask

    task automatic test_reset();
        quiet();
        rsn_i = 0;
        model_reset();
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (obs_now() !== {99'd0, 1'b0, 1'b1, 1'b1} && obs_now() !== {99'd0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, expected zero buffer with stall=1", obs_now());
        end
        rsn_i = 1;
        @(negedge clk_i);
        model_pc = 32'h1000;
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1000 || stall_fetch_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: req=%b addr=%h stall=%b, expected 1 00001000 1", imem_req_o, imem_addr_o, stall_fetch_o);
        end
        $display("reset released");
    endtask

    task automatic test_first_fetch();
        do_fetch(1, 32'h0000_0013, 0, 0, 0);
    endtask

    task automatic test_btb_taken();
        bp_update_i = 1; bp_update_pc_i = 32'h1008; bp_update_target_i = 32'h2000; bp_update_taken_i = 1;
        model_update(32'h1008, 32'h2000, 1);
        @(negedge clk_i);
        bp_update_i = 0;
        do_fetch(0, 32'h0000_0093, 0, 0, 0);
        do_fetch(0, 32'h0000_0063, 0, 0, 0);
        n_cmp++;
        if (imem_addr_o !== 32'h2000 || imem_req_o !== 1'b1) begin
            n_err++;
            $display("FAIL btb_taken_next: addr=%h req=%b, expected 00002000 1", imem_addr_o, imem_req_o);
        end
    endtask

    task automatic test_ctr_saturate();
        for (int k = 0; k < 3; k++) begin
            bp_update_i = 1; bp_update_pc_i = 32'h1008; bp_update_target_i = 32'h2000; bp_update_taken_i = 0;
            model_update(32'h1008, 32'h2000, 0);
            @(negedge clk_i);
        end
        bp_update_i = 0;
        redirect_to(32'h1008, 0);
        do_fetch(0, 32'h0000_0063, 0, 0, 0);
        n_cmp++;
        if (imem_addr_o !== 32'h100C) begin
            n_err++;
            $display("FAIL ctr_saturate_next: addr=%h, expected 0000100c", imem_addr_o);
        end
    endtask

    task automatic test_redirect_flush();
        redirect_to(32'h1004, 0);
        redirect_i = 1; redirect_pc_i = 32'h3000;
        @(negedge clk_i);
        redirect_i = 0;
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1004 || stall_fetch_o !== 1'b1 || fetch_instr_o !== 32'd0) begin
                n_err++;
                $display("FAIL flush_hold %0d: req=%b addr=%h stall=%b instr=%h, expected 1 00001004 1 0", c,
                         imem_req_o, imem_addr_o, stall_fetch_o, fetch_instr_o);
            end
            if (c == 3) begin imem_ack_i = 1; imem_data_i = 32'hDEAD_BEEF; end
            @(negedge clk_i);
        end
        imem_ack_i = 0;
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3000 || stall_fetch_o !== 1'b1 || fetch_instr_o !== 32'd0) begin
            n_err++;
            $display("FAIL flush_exit: req=%b addr=%h stall=%b instr=%h, expected 1 00003000 1 0",
                     imem_req_o, imem_addr_o, stall_fetch_o, fetch_instr_o);
        end
        $display("flush drained, next request %h", imem_addr_o);
        model_pc = 32'h3000;
        do_fetch(2, 32'h0000_0033, 0, 0, 0);
    endtask

    task automatic test_misaligned_fault();
        redirect_to(32'h3002, 0);
        @(negedge clk_i);
        n_cmp++;
        if (fetch_misaligned_instr_exc_o !== 1'b1 || fetch_instr_o !== 32'd0 || fetch_pc_o !== 32'h3002 ||
            fetch_instr_fault_exc_o !== 1'b0 || fetch_prediction_o !== 1'b0 || stall_fetch_o !== 1'b0 || imem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL misaligned: mis=%b instr=%h pc=%h flt=%b pred=%b stall=%b req=%b, expected 1 0 00003002 0 0 0 0",
                     fetch_misaligned_instr_exc_o, fetch_instr_o, fetch_pc_o, fetch_instr_fault_exc_o,
                     fetch_prediction_o, stall_fetch_o, imem_req_o);
        end
        $display("misaligned fetch at 00003002");
        redirect_to(32'h3000, 0);
        do_fetch(1, 32'h1234_5678, 1, 0, 0);
    endtask

    task automatic test_stall_wrap();
        do_fetch(0, 32'h0000_0013, 0, 0, 4);
        redirect_to(32'hFFFF_FFFC, 0);
        do_fetch(0, 32'h0000_0013, 0, 0, 0);
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL pc_wrap: req=%b addr=%h, expected 1 00000000", imem_req_o, imem_addr_o);
        end
        redirect_to(32'h1000, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) redirect_to(rand_pc(), 1'($urandom_range(0, 1)));
            do_fetch(int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_reset_async();
        imem_ack_i = 1; imem_data_i = 32'h0000_0013; stall_core_i = 1;
        @(negedge clk_i);
        imem_ack_i = 0;
        #2 rsn_i = 0;
        #1;
        n_cmp++;
        if (stall_fetch_o !== 1'b1 || fetch_instr_o !== 32'd0 || fetch_pc_o !== 32'd0 ||
            imem_req_o !== 1'b1 || imem_addr_o !== 32'h1000) begin
            n_err++;
            $display("FAIL async_reset: stall=%b instr=%h pc=%h req=%b addr=%h, expected 1 0 0 1 00001000",
                     stall_fetch_o, fetch_instr_o, fetch_pc_o, imem_req_o, imem_addr_o);
        end
        stall_core_i = 0;
        @(negedge clk_i);
        rsn_i = 1;
        model_reset();
        model_pc = 32'h1000;
        $display("async reset applied mid-transaction");
        @(negedge clk_i);
        do_fetch(0, 32'h0000_0013, 0, 0, 0);
        do_fetch(1, 32'h0000_0013, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_btb_taken();
        test_ctr_saturate();
        test_redirect_flush();
        test_misaligned_fault();
        test_stall_wrap();
        test_random();
        test_reset_async();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
